// File: rtl/shape_pkg.sv
// Shared shape encodings and changeover FSM states for the shape pulse mux datapath.
// The one-hot helper is used wherever a switch vector has to be validated.
package shape_pkg;

  localparam logic [3:0] SHAPE_CIRCLE = 4'b0001;
  localparam logic [3:0] SHAPE_EIGHT  = 4'b0010;
  localparam logic [3:0] SHAPE_SQUARE = 4'b0100;
  localparam logic [3:0] SHAPE_SOLID  = 4'b1000;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus whole-vector debounce: a new switch vector is accepted only after
// it has held steady for DEB_CYCLES consecutive counting cycles; any movement restarts the count.
module sw_debounce
  import shape_pkg::*;
#(
  parameter int unsigned W          = 4,
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYCLES - 1);

  logic [W-1:0]    sync1_q, sync_q, prev_q;
  logic [W-1:0]    stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= '0;
      sync_q   <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync_q   <= sync1_q;
      prev_q   <= sync_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // Count only while the synchronised vector is both new and unchanged since last cycle.
    if ((sync_q == stable_q) || (sync_q != prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      stable_d = sync_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/shape_select_ctrl.sv
// Conditions raw shape switches into a registered one-hot enable, with a fixed blanking gap
// between shapes so the downstream pattern generators restart from a known phase.
module shape_select_ctrl
  import shape_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned GAP_CYCLES = 1000
) (
  input  logic       sysclk,
  input  logic       sysrst_n,
  input  logic [3:0] raw_sw,
  output logic [3:0] enable_sw,
  output logic       sel_valid,
  output logic       changing
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam logic [GapW-1:0] GapMax = GapW'(GAP_CYCLES - 1);

  logic [3:0]      stable_sw;
  logic [3:0]      cand;
  logic            cand_valid;
  state_e          state_q, state_d;
  logic [3:0]      tgt_q, tgt_d;
  logic [3:0]      cur_sel_q, cur_sel_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [3:0]      enable_q, enable_d;
  logic            sel_valid_q, sel_valid_d;
  logic            changing_q, changing_d;

  sw_debounce #(
    .W          (4),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_sw_debounce (
    .clk_i    (sysclk),
    .rst_ni   (sysrst_n),
    .raw_i    (raw_sw),
    .stable_o (stable_sw)
  );

  // Anything other than exactly one switch falls back to the circle.
  assign cand_valid = is_onehot4(stable_sw);
  assign cand       = cand_valid ? stable_sw : SHAPE_CIRCLE;

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      state_q   <= ST_BLANK;
      tgt_q     <= SHAPE_CIRCLE;
      cur_sel_q <= SHAPE_CIRCLE;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cur_sel_q <= cur_sel_d;
      gap_q     <= gap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cur_sel_d = cur_sel_q;
    gap_d     = gap_q;
    unique case (state_q)
      ST_RUN: begin
        if (cand != cur_sel_q) begin
          state_d = ST_BLANK;
          tgt_d   = cand;
          gap_d   = '0;
        end
      end
      ST_BLANK: begin
        // A moving target restarts the gap so the blank always ends a full gap after it settles.
        if (cand != tgt_q) begin
          tgt_d = cand;
          gap_d = '0;
        end else if (gap_q == GapMax) begin
          state_d   = ST_RUN;
          cur_sel_d = tgt_q;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    enable_d    = (state_d == ST_RUN) ? cur_sel_d : 4'b0000;
    changing_d  = (state_d == ST_BLANK);
    sel_valid_d = cand_valid;
  end

  always_ff @(posedge sysclk or negedge sysrst_n) begin
    if (!sysrst_n) begin
      enable_q    <= 4'b0000;
      sel_valid_q <= 1'b0;
      changing_q  <= 1'b1;
    end else begin
      enable_q    <= enable_d;
      sel_valid_q <= sel_valid_d;
      changing_q  <= changing_d;
    end
  end

  assign enable_sw = enable_q;
  assign sel_valid = sel_valid_q;
  assign changing  = changing_q;

endmodule

// File: tb/tb_shape_select_ctrl.sv
// Bench for shape_select_ctrl: directed scenarios plus randomized switch traffic, checked
// against a window/run-length reference model of debounce and blanking.
module tb_shape_select_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned GAP = 3;

  logic       sysclk = 1'b0;
  logic       sysrst_n = 1'b0;
  logic [3:0] raw_sw = 4'b0000;
  logic [3:0] enable_sw;
  logic       sel_valid;
  logic       changing;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [3:0] hist[$];
  logic [3:0] m_stable, m_last, m_en;
  logic       m_valid, m_chg;
  int         m_n;

  shape_select_ctrl #(
    .DEB_CYCLES (DEB),
    .GAP_CYCLES (GAP)
  ) dut (
    .sysclk    (sysclk),
    .sysrst_n  (sysrst_n),
    .raw_sw    (raw_sw),
    .enable_sw (enable_sw),
    .sel_valid (sel_valid),
    .changing  (changing)
  );

  always #5 sysclk = ~sysclk;

  task automatic model_reset();
    hist = {};
    for (int i = 0; i < DEB + 2; i++) hist.push_back(4'b0000);
    m_stable = 4'b0000;
    m_last   = 4'b0001;
    m_n      = 0;
    m_en     = 4'b0000;
    m_valid  = 1'b0;
    m_chg    = 1'b1;
  endtask

  // One clock: drive raw, advance the model on the edge, settle past the edge.
  // A switch vector is accepted once DEB+1 consecutive samples agree and differ from the
  // accepted value; a shape is shown once the candidate has held for GAP edges.
  task automatic step(input logic [3:0] v);
    logic [3:0] c;
    logic       ok1h, upd;
    raw_sw = v;
    @(posedge sysclk);
    ok1h    = ($countones(m_stable) == 1);
    c       = ok1h ? m_stable : 4'b0001;
    m_valid = ok1h;
    if (c != m_last) begin
      m_last = c;
      m_n    = 0;
    end else if (m_n < GAP) begin
      m_n++;
    end
    upd = (hist[1] != m_stable);
    for (int i = 2; i <= DEB + 1; i++) if (hist[i] != hist[1]) upd = 1'b0;
    if (upd) m_stable = hist[1];
    hist.push_front(v);
    void'(hist.pop_back());
    m_en  = (m_n >= GAP) ? m_last : 4'b0000;
    m_chg = (m_n < GAP);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge sysclk);
    sysrst_n = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge sysclk);
    sysrst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    raw_sw = 4'b0000;
    apply_reset();
    n_vec++;
    if ({enable_sw, sel_valid, changing} !== 6'b0000_0_1) begin
      n_err++;
      $display("FAIL reset_assert: got en=%b valid=%b chg=%b, want en=0000 valid=0 chg=1",
               enable_sw, sel_valid, changing);
    end
    release_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'b0000);
      n_vec++;
      if (enable_sw !== ((i >= 2) ? 4'b0001 : 4'b0000) || changing !== (i < 2)
          || sel_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_exit cyc%0d: got en=%b valid=%b chg=%b, want en=%b valid=0 chg=%b",
                 i, enable_sw, sel_valid, changing, (i >= 2) ? 4'b0001 : 4'b0000, i < 2);
      end
    end
  endtask

  task automatic test_clean_select();
    for (int i = 0; i < 14; i++) begin
      step(4'b0100);
      n_vec++;
      if ({enable_sw, sel_valid, changing} !== {m_en, m_valid, m_chg}) begin
        n_err++;
        $display("FAIL clean_select cyc%0d: got en=%b valid=%b chg=%b, want en=%b valid=%b chg=%b",
                 i, enable_sw, sel_valid, changing, m_en, m_valid, m_chg);
      end
    end
    n_vec++;
    if (enable_sw !== 4'b0100 || sel_valid !== 1'b1) begin
      n_err++;
      $display("FAIL clean_select_final: got en=%b valid=%b, want en=0100 valid=1",
               enable_sw, sel_valid);
    end
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 10; t++) begin
      int hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        step(t[0] ? 4'b0000 : 4'b0010);
        n_vec++;
        if ({enable_sw, sel_valid, changing} !== {m_en, m_valid, m_chg}) begin
          n_err++;
          $display("FAIL bounce t%0d: got en=%b valid=%b chg=%b, want en=%b valid=%b chg=%b",
                   t, enable_sw, sel_valid, changing, m_en, m_valid, m_chg);
        end
      end
    end
    for (int i = 0; i < 14; i++) begin
      step(4'b0010);
      n_vec++;
      if ({enable_sw, sel_valid, changing} !== {m_en, m_valid, m_chg}) begin
        n_err++;
        $display("FAIL bounce_settle cyc%0d: got en=%b valid=%b chg=%b, want en=%b valid=%b chg=%b",
                 i, enable_sw, sel_valid, changing, m_en, m_valid, m_chg);
      end
    end
    n_vec++;
    if (enable_sw !== 4'b0010) begin
      n_err++;
      $display("FAIL bounce_final: got en=%b, want en=0010", enable_sw);
    end
  endtask

  task automatic test_multi_hot();
    for (int i = 0; i < 14; i++) begin
      step(4'b0110);
      n_vec++;
      if ({enable_sw, sel_valid, changing} !== {m_en, m_valid, m_chg}
          || enable_sw === 4'b0110) begin
        n_err++;
        $display("FAIL multi_hot cyc%0d: got en=%b valid=%b chg=%b, want en=%b valid=%b chg=%b",
                 i, enable_sw, sel_valid, changing, m_en, m_valid, m_chg);
      end
    end
    n_vec++;
    if (enable_sw !== 4'b0001 || sel_valid !== 1'b0) begin
      n_err++;
      $display("FAIL multi_hot_final: got en=%b valid=%b, want en=0001 valid=0",
               enable_sw, sel_valid);
    end
  endtask

  task automatic test_retarget();
    int hold = $urandom_range(4, 8);
    for (int i = 0; i < hold + 14; i++) begin
      step((i < hold) ? 4'b1000 : 4'b0100);
      n_vec++;
      if ({enable_sw, sel_valid, changing} !== {m_en, m_valid, m_chg}) begin
        n_err++;
        $display("FAIL retarget cyc%0d: got en=%b valid=%b chg=%b, want en=%b valid=%b chg=%b",
                 i, enable_sw, sel_valid, changing, m_en, m_valid, m_chg);
      end
    end
  endtask

  task automatic test_reset_mid_blank();
    int guard = 0;
    step(4'b1000);
    while (!(m_chg && m_last == 4'b1000) && guard < 20) begin
      step(4'b1000);
      guard++;
    end
    n_vec++;
    if (changing !== 1'b1 || guard >= 20) begin
      n_err++;
      $display("FAIL mid_blank_reach: got chg=%b after %0d cycles, want chg=1", changing, guard);
    end
    apply_reset();
    n_vec++;
    if ({enable_sw, sel_valid, changing} !== 6'b0000_0_1) begin
      n_err++;
      $display("FAIL mid_blank_reset: got en=%b valid=%b chg=%b, want en=0000 valid=0 chg=1",
               enable_sw, sel_valid, changing);
    end
    release_reset();
    for (int i = 0; i < 16; i++) begin
      step(4'b1000);
      n_vec++;
      if ({enable_sw, sel_valid, changing} !== {m_en, m_valid, m_chg}) begin
        n_err++;
        $display("FAIL mid_blank_recover cyc%0d: got en=%b valid=%b chg=%b, want en=%b valid=%b chg=%b",
                 i, enable_sw, sel_valid, changing, m_en, m_valid, m_chg);
      end
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 60; b++) begin
      logic [3:0] v;
      int hold = $urandom_range(1, 10);
      v = ($urandom_range(0, 1) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      for (int h = 0; h < hold; h++) begin
        step(v);
        n_vec++;
        if ({enable_sw, sel_valid, changing} !== {m_en, m_valid, m_chg}) begin
          n_err++;
          $display("FAIL random b%0d h%0d: got en=%b valid=%b chg=%b, want en=%b valid=%b chg=%b",
                   b, h, enable_sw, sel_valid, changing, m_en, m_valid, m_chg);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_select();
    test_bounce();
    test_multi_hot();
    test_retarget();
    test_reset_mid_blank();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
